// File: rtl/ika9958_vram_slot_arb_pkg.sv
// -----------------------------------------------------------------------------
// IKA9958_mnemonics
//   Shared names for the VRAM slot arbiter and its neighbours.
//
//   slot_owner_t      : who owns the current VRAM access slot
//   SLOT_LEN          : pixel clocks per access slot (comcntr[1:0] rolls over)
//   TXT_TILE_SLOTS    : access slots in a 12px text tile
//   GFX_TILE_SLOTS    : access slots in a 16px graphics tile
//   is_slot_boundary(): true when a comcntr value opens a new slot
// -----------------------------------------------------------------------------
package IKA9958_mnemonics;

  typedef enum logic [2:0] {
    OWN_IDLE    = 3'd0,
    OWN_DISP    = 3'd1,
    OWN_REFRESH = 3'd2,
    OWN_CPU     = 3'd3,
    OWN_CMD     = 3'd4
  } slot_owner_t;

  localparam int SLOT_LEN       = 4;
  localparam int TXT_TILE_SLOTS = 3;
  localparam int GFX_TILE_SLOTS = 4;

  // A slot starts whenever the counter value itself sits on a slot-aligned
  // position. Looking at the value, not at an increment, makes counter
  // reloads and repeated values behave consistently.
  function automatic logic is_slot_boundary(input logic [8:0] cnt);
    return cnt[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ika9958_vram_slot_arb_rr.sv
// -----------------------------------------------------------------------------
// ika9958_vram_slot_arb_rr
//   Two-requester round-robin. Grants are combinational from the requests;
//   the "last granted" register only moves when the caller commits a grant.
//   After reset requester B is treated as the last one served, so A wins the
//   first contested round.
//
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   advance  in  commit this cycle's grant (updates the fairness state)
//   req_a    in  request from requester A
//   req_b    in  request from requester B
//   grant_a  out A would be granted this cycle
//   grant_b  out B would be granted this cycle
// -----------------------------------------------------------------------------
module ika9958_vram_slot_arb_rr (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  logic last_b;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      // Contested: serve whichever side was not served last.
      grant_a = last_b;
      grant_b = !last_b;
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values that existed before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (advance && (grant_a || grant_b)) begin
      last_b <= grant_b;
    end
  end

endmodule

// File: rtl/ika9958_vram_slot_arb.sv
// -----------------------------------------------------------------------------
// ika9958_vram_slot_arb
//   Hands out VRAM access slots derived from the common PLA counter. At each
//   slot boundary one owner is chosen (refresh, display fetch, CPU port or
//   command engine) and registered; it holds until the next boundary.
//
//   Optional feature, macro IKA9958_VRAM_ARB_STATS_EN: per-requester 16-bit
//   saturating grant counters with a synchronous clear.
//
//   Ports
//   phiA           in  master clock
//   RST_async      in  asynchronous active-high reset
//   phiL_NCEN      in  pixel clock enable; all arbitration state advances
//                      only when high
//   comcntr[8:0]   in  common PLA counter, [8:4] tile, [3:0] pixel
//   txt_mode       in  text (T1/T2) tile geometry
//   disp_active    in  inside the active display region
//   cpu_req        in  CPU port request, level, held until ack
//   cpu_ack        out one-cycle grant pulse to the CPU port
//   cmd_req        in  command engine request, level, held until ack
//   cmd_ack        out one-cycle grant pulse to the command engine
//   slot_start     out one-cycle pulse at the first cycle of a new slot
//   slot_owner[2:0] out owner of the current slot (slot_owner_t encoding)
//   stats_clr      in  (stats build) synchronous counter clear
//   cpu_grant_cnt  out (stats build) CPU grants issued, saturating
//   cmd_grant_cnt  out (stats build) command engine grants, saturating
// -----------------------------------------------------------------------------
module ika9958_vram_slot_arb
  import IKA9958_mnemonics::*;
#(
  parameter logic [8:0] REFRESH_POS    = 9'h1F8,
  parameter int         TXT_DISP_SLOTS = 2,
  parameter int         GFX_DISP_SLOTS = 3
) (
  input  logic       phiA,
  input  logic       RST_async,
  input  logic       phiL_NCEN,
  input  logic [8:0] comcntr,
  input  logic       txt_mode,
  input  logic       disp_active,
  input  logic       cpu_req,
  output logic       cpu_ack,
  input  logic       cmd_req,
  output logic       cmd_ack,
  output logic       slot_start,
  output logic [2:0] slot_owner
`ifdef IKA9958_VRAM_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] cpu_grant_cnt,
  output logic [15:0] cmd_grant_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: the refresh slot must itself be a slot boundary, and a
  // tile cannot hand more slots to display than it has.
  // ---------------------------------------------------------------------------
  if ((REFRESH_POS % SLOT_LEN) != 0) begin : g_bad_refresh_pos
    $error("REFRESH_POS must be aligned to a slot boundary");
  end
  if (TXT_DISP_SLOTS > TXT_TILE_SLOTS || GFX_DISP_SLOTS > GFX_TILE_SLOTS) begin : g_bad_disp_slots
    $error("display slot count exceeds the slots available in a tile");
  end

  // ---------------------------------------------------------------------------
  // Slot decode
  // ---------------------------------------------------------------------------
  logic        boundary;
  logic [1:0]  slot_idx;
  logic [2:0]  disp_limit;
  logic        is_refresh;
  logic        is_disp;
  logic        slot_free;

  assign boundary   = phiL_NCEN && is_slot_boundary(comcntr);
  assign slot_idx   = comcntr[3:2];
  assign disp_limit = txt_mode ? 3'(TXT_DISP_SLOTS) : 3'(GFX_DISP_SLOTS);

  // Refresh is mandatory once per line and overrides display fetch.
  assign is_refresh = (comcntr == REFRESH_POS);
  assign is_disp    = disp_active && ({1'b0, slot_idx} < disp_limit);
  assign slot_free  = !is_refresh && !is_disp;

  // ---------------------------------------------------------------------------
  // Free-slot round-robin between CPU port (A) and command engine (B)
  // ---------------------------------------------------------------------------
  logic rr_grant_cpu;
  logic rr_grant_cmd;
  logic grant_cpu;
  logic grant_cmd;

  ika9958_vram_slot_arb_rr u_rr (
    .clk     (phiA),
    .rst     (RST_async),
    .advance (boundary && slot_free),
    .req_a   (cpu_req),
    .req_b   (cmd_req),
    .grant_a (rr_grant_cpu),
    .grant_b (rr_grant_cmd)
  );

  assign grant_cpu = slot_free && rr_grant_cpu;
  assign grant_cmd = slot_free && rr_grant_cmd;

  // ---------------------------------------------------------------------------
  // Owner selection for the slot that opens this cycle
  // ---------------------------------------------------------------------------
  slot_owner_t next_owner;

  always_comb begin
    next_owner = OWN_IDLE;
    if (is_refresh) begin
      next_owner = OWN_REFRESH;
    end else if (is_disp) begin
      next_owner = OWN_DISP;
    end else if (grant_cpu) begin
      next_owner = OWN_CPU;
    end else if (grant_cmd) begin
      next_owner = OWN_CMD;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Pulses self-clear on the following phiA cycle even
  // when the pixel enable is low; the owner only changes on a boundary.
  // ---------------------------------------------------------------------------
  slot_owner_t owner_q;

  always_ff @(posedge phiA or posedge RST_async) begin
    if (RST_async) begin
      owner_q    <= OWN_IDLE;
      slot_start <= 1'b0;
      cpu_ack    <= 1'b0;
      cmd_ack    <= 1'b0;
    end else begin
      slot_start <= 1'b0;
      cpu_ack    <= 1'b0;
      cmd_ack    <= 1'b0;
      if (boundary) begin
        owner_q    <= next_owner;
        slot_start <= 1'b1;
        cpu_ack    <= grant_cpu;
        cmd_ack    <= grant_cmd;
      end
    end
  end

  assign slot_owner = owner_q;

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef IKA9958_VRAM_ARB_STATS_EN
  // Counters step on the same edge that raises the matching ack, so each
  // value reflects the acks issued so far. Clear wins over a coincident grant
  // and does not depend on the pixel enable.
  always_ff @(posedge phiA or posedge RST_async) begin
    if (RST_async) begin
      cpu_grant_cnt <= 16'h0000;
      cmd_grant_cnt <= 16'h0000;
    end else if (stats_clr) begin
      cpu_grant_cnt <= 16'h0000;
      cmd_grant_cnt <= 16'h0000;
    end else begin
      if (boundary && grant_cpu && (cpu_grant_cnt != 16'hFFFF)) begin
        cpu_grant_cnt <= cpu_grant_cnt + 16'h0001;
      end
      if (boundary && grant_cmd && (cmd_grant_cnt != 16'hFFFF)) begin
        cmd_grant_cnt <= cmd_grant_cnt + 16'h0001;
      end
    end
  end
`else
  // Statistics build disabled: no counters, arbitration is unchanged.
`endif

endmodule

// File: tb/tb_ika9958_vram_slot_arb.sv
// -----------------------------------------------------------------------------
// tb_ika9958_vram_slot_arb
//   Directed stimulus with hand-written expected slot outcomes. Each boundary
//   the stimulus opens pushes its expected {owner, cpu_ack, cmd_ack} into a
//   queue; a monitor on the falling edge pops an entry whenever slot_start is
//   seen and otherwise checks that the owner holds and no ack leaks out.
// -----------------------------------------------------------------------------
module tb_ika9958_vram_slot_arb;
  import IKA9958_mnemonics::*;

  typedef struct packed {
    slot_owner_t own;
    logic        ca;
    logic        ma;
  } exp_t;

  logic       phiA;
  logic       RST_async;
  logic       phiL_NCEN;
  logic [8:0] comcntr;
  logic       txt_mode;
  logic       disp_active;
  logic       cpu_req;
  logic       cpu_ack;
  logic       cmd_req;
  logic       cmd_ack;
  logic       slot_start;
  logic [2:0] slot_owner;
`ifdef IKA9958_VRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] cpu_grant_cnt;
  logic [15:0] cmd_grant_cnt;
`endif

  ika9958_vram_slot_arb dut (
    .phiA        (phiA),
    .RST_async   (RST_async),
    .phiL_NCEN   (phiL_NCEN),
    .comcntr     (comcntr),
    .txt_mode    (txt_mode),
    .disp_active (disp_active),
    .cpu_req     (cpu_req),
    .cpu_ack     (cpu_ack),
    .cmd_req     (cmd_req),
    .cmd_ack     (cmd_ack),
    .slot_start  (slot_start),
    .slot_owner  (slot_owner)
`ifdef IKA9958_VRAM_ARB_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .cpu_grant_cnt (cpu_grant_cnt),
    .cmd_grant_cnt (cmd_grant_cnt)
`endif
  );

  initial phiA = 1'b0;
  always #5 phiA = ~phiA;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t plan[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input slot_owner_t own, input logic ca, input logic ma);
    exp_t e;
    e.own = own;
    e.ca  = ca;
    e.ma  = ma;
    return e;
  endfunction

  // Called at posedge+1: apply inputs for one phiA cycle, queue the expected
  // slot if this cycle opens one, and move on to the next posedge+1.
  task automatic drive(input logic [8:0] c, input logic ce, input logic bnd, input exp_t e);
    comcntr   = c;
    phiL_NCEN = ce;
    if (bnd) exp_q.push_back(e);
    @(posedge phiA);
    #1;
  endtask

  // Walk comcntr upward with the enable high; every slot-aligned value takes
  // the next hand-written outcome from plan.
  task automatic sweep(input logic [8:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0] c;
      c = start + 9'(i);
      if (c[1:0] == 2'b00) begin
        if (plan.size() == 0) begin
          check("plan underrun", 32'(c), 32'h1FF);
          drive(c, 1'b1, 1'b0, mk(OWN_IDLE, 1'b0, 1'b0));
        end else begin
          drive(c, 1'b1, 1'b1, plan.pop_front());
        end
      end else begin
        drive(c, 1'b1, 1'b0, mk(OWN_IDLE, 1'b0, 1'b0));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  slot_owner_t cur_own = OWN_IDLE;
  exp_t        got;

  always @(negedge phiA) begin
    if (RST_async) begin
      cur_own = OWN_IDLE;
    end else if (slot_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected slot_start", 32'(slot_start), 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("slot owner", 32'(slot_owner), 32'(got.own));
        check("cpu_ack", 32'(cpu_ack), 32'(got.ca));
        check("cmd_ack", 32'(cmd_ack), 32'(got.ma));
        cur_own = got.own;
      end
    end else begin
      check("owner hold", 32'(slot_owner), 32'(cur_own));
      check("stray ack", 32'({cpu_ack, cmd_ack}), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  exp_t nb;

  initial begin
    nb          = mk(OWN_IDLE, 1'b0, 1'b0);
    RST_async   = 1'b1;
    phiL_NCEN   = 1'b0;
    comcntr     = 9'h000;
    txt_mode    = 1'b0;
    disp_active = 1'b0;
    cpu_req     = 1'b0;
    cmd_req     = 1'b0;
`ifdef IKA9958_VRAM_ARB_STATS_EN
    stats_clr   = 1'b0;
`endif
    @(posedge phiA);
    #1;
    check("reset owner", 32'(slot_owner), 32'(OWN_IDLE));
    check("reset slot_start", 32'(slot_start), 32'd0);
    check("reset acks", 32'({cpu_ack, cmd_ack}), 32'd0);
`ifdef IKA9958_VRAM_ARB_STATS_EN
    check("reset cpu_grant_cnt", 32'(cpu_grant_cnt), 32'd0);
    check("reset cmd_grant_cnt", 32'(cmd_grant_cnt), 32'd0);
`endif
    @(posedge phiA);
    #1;
    RST_async = 1'b0;
    drive(9'h000, 1'b0, 1'b0, nb);

    // Free slots, both requesters always asking: CPU first after reset.
    cpu_req = 1'b1;
    cmd_req = 1'b1;
    plan.push_back(mk(OWN_CPU, 1'b1, 1'b0));
    plan.push_back(mk(OWN_CMD, 1'b0, 1'b1));
    plan.push_back(mk(OWN_CPU, 1'b1, 1'b0));
    plan.push_back(mk(OWN_CMD, 1'b0, 1'b1));
    sweep(9'h000, 16);

    // Repeated aligned value is a fresh boundary each enabled cycle; with the
    // enable low the same value opens nothing.
    cmd_req = 1'b0;
    drive(9'h010, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    drive(9'h010, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    drive(9'h010, 1'b0, 1'b0, nb);
    drive(9'h010, 1'b0, 1'b0, nb);
    cpu_req = 1'b0;
    drive(9'h011, 1'b0, 1'b0, nb);

    // Graphics tile during display: three display slots, CMD gets slot 3.
    disp_active = 1'b1;
    cmd_req     = 1'b1;
    plan.push_back(mk(OWN_DISP, 1'b0, 1'b0));
    plan.push_back(mk(OWN_DISP, 1'b0, 1'b0));
    plan.push_back(mk(OWN_DISP, 1'b0, 1'b0));
    plan.push_back(mk(OWN_CMD, 1'b0, 1'b1));
    sweep(9'h050, 16);
    cmd_req = 1'b0;
    drive(9'h05F, 1'b0, 1'b0, nb);

    // Text tile: two display slots, CPU gets slot 2, then a reload to an
    // unaligned value opens nothing until the next aligned value.
    txt_mode = 1'b1;
    cpu_req  = 1'b1;
    plan.push_back(mk(OWN_DISP, 1'b0, 1'b0));
    plan.push_back(mk(OWN_DISP, 1'b0, 1'b0));
    plan.push_back(mk(OWN_CPU, 1'b1, 1'b0));
    sweep(9'h060, 12);
    drive(9'h06D, 1'b1, 1'b0, nb);
    drive(9'h06E, 1'b1, 1'b0, nb);
    drive(9'h06F, 1'b1, 1'b0, nb);
    drive(9'h070, 1'b1, 1'b1, mk(OWN_DISP, 1'b0, 1'b0));
    cpu_req  = 1'b0;
    txt_mode = 1'b0;
    drive(9'h071, 1'b0, 1'b0, nb);

    // Refresh slot overrides display and a pending CPU request; CPU then takes
    // graphics slot 3 of the same tile.
    cpu_req = 1'b1;
    drive(9'h1F8, 1'b1, 1'b1, mk(OWN_REFRESH, 1'b0, 1'b0));
    drive(9'h1F9, 1'b1, 1'b0, nb);
    drive(9'h1FA, 1'b1, 1'b0, nb);
    drive(9'h1FB, 1'b1, 1'b0, nb);
    drive(9'h1FC, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    cpu_req     = 1'b0;
    disp_active = 1'b0;
    drive(9'h1FD, 1'b0, 1'b0, nb);

    // Reset in the middle of a CPU slot, with both requests pending.
    cpu_req = 1'b1;
    drive(9'h020, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    cmd_req = 1'b1;
    drive(9'h021, 1'b1, 1'b0, nb);
    #1;
    RST_async = 1'b1;
    #1;
    check("async reset owner", 32'(slot_owner), 32'(OWN_IDLE));
    check("async reset slot_start", 32'(slot_start), 32'd0);
    check("async reset acks", 32'({cpu_ack, cmd_ack}), 32'd0);
    @(posedge phiA);
    #1;
    RST_async = 1'b0;
    drive(9'h021, 1'b1, 1'b0, nb);
    // Fairness state restarted: CPU wins even though it was served last.
    plan.push_back(mk(OWN_CPU, 1'b1, 1'b0));
    plan.push_back(mk(OWN_CMD, 1'b0, 1'b1));
    sweep(9'h024, 8);
    cpu_req = 1'b0;
    cmd_req = 1'b0;
    drive(9'h02C, 1'b0, 1'b0, nb);

`ifdef IKA9958_VRAM_ARB_STATS_EN
    stats_clr = 1'b1;
    drive(9'h000, 1'b0, 1'b0, nb);
    stats_clr = 1'b0;
    check("cleared cpu_grant_cnt", 32'(cpu_grant_cnt), 32'd0);
    check("cleared cmd_grant_cnt", 32'(cmd_grant_cnt), 32'd0);
    cpu_req = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      drive(9'h000, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    end
    drive(9'h001, 1'b0, 1'b0, nb);
    check("saturated cpu_grant_cnt", 32'(cpu_grant_cnt), 32'hFFFF);
    check("idle cmd_grant_cnt", 32'(cmd_grant_cnt), 32'd0);
    stats_clr = 1'b1;
    drive(9'h000, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    stats_clr = 1'b0;
    check("clear beats grant", 32'(cpu_grant_cnt), 32'd0);
    drive(9'h000, 1'b1, 1'b1, mk(OWN_CPU, 1'b1, 1'b0));
    check("count after clear", 32'(cpu_grant_cnt), 32'd1);
    cpu_req = 1'b0;
`endif

    drive(9'h001, 1'b0, 1'b0, nb);
    drive(9'h001, 1'b0, 1'b0, nb);
    drive(9'h001, 1'b0, 1'b0, nb);
    check("expected slots outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ika9958_vram_slot_arb.md
Name: ika9958_vram_slot_arb

Overview:
- Schedules VRAM access slots from the common PLA counter (comcntr).
- Each slot goes to one owner: display fetch, refresh, CPU port or command engine.
- Sits between the PLA counter / register file and the VRAM controller; one owner per slot, registered.

Parameters:
REFRESH_POS, 9'h1F8, comcntr value of the per-line mandatory refresh slot; bits [1:0] must be 0
TXT_DISP_SLOTS, 2, display-owned slots per 12px text tile (slot indices 0..N-1)
GFX_DISP_SLOTS, 3, display-owned slots per 16px graphics tile

Ports:
phiA  in  1  master clock
RST_async  in  1  reset, asynchronous, active-high
phiL_NCEN  in  1  pixel-cycle clock enable; all state advances only when high
comcntr  in  9  common PLA counter: [8:4] tile, [3:0] pixel
txt_mode  in  1  register mode is T1 or T2
disp_active  in  1  active display region (line and horizontal)
cpu_req  in  1  CPU port access request, level, held until ack
cpu_ack  out  1  one-phiA-cycle grant pulse to CPU port
cmd_req  in  1  command engine request, level, held until ack
cmd_ack  out  1  one-phiA-cycle grant pulse to command engine
slot_start  out  1  pulse marking the first cycle of a new slot
slot_owner  out  3  owner of the current slot (slot_owner_t)

Behaviour:
- Reset (async, active-high): slot_owner=OWN_IDLE; slot_start, cpu_ack, cmd_ack=0; last_free=OWN_CMD.
- Slot boundary: phiL_NCEN=1 and comcntr[1:0]==2'b00. slot_idx=comcntr[3:2].
- Text tiles give slots 0..2 (comcntr[3:0] 0..11). Graphics tiles give slots 0..3.
- Priority at each boundary, evaluated from current inputs:
  1. comcntr==REFRESH_POS -> OWN_REFRESH (unconditional, even if disp_active=1).
  2. disp_active and slot_idx < (txt_mode ? TXT_DISP_SLOTS : GFX_DISP_SLOTS) -> OWN_DISP.
  3. Otherwise the slot is free: cpu_req only -> CPU; cmd_req only -> CMD; both -> the one not equal to last_free; neither -> OWN_IDLE.
- Outputs are registered on the boundary edge, visible the next phiA cycle.
  - slot_owner holds until the next boundary.
  - slot_start is high for exactly one phiA cycle.
  - The ack of the granted requester pulses with slot_start.
- last_free updates only on CPU/CMD grants.
- A request must be stable at the boundary edge to be seen. A request raised mid-slot waits for the next free slot.
- A requester drops req the cycle after its ack. A req still high then is treated as a new request.
- comcntr loads to a value with [1:0]!=0 (eq23, EndOfTile reload): no boundary; the current owner holds until the next [1:0]==0.
- Boundaries are detected on the comcntr value, never on an increment, so a load to a [1:0]==0 value is a boundary.
- Each CE cycle with [1:0]==0 is a new boundary, even if comcntr repeats.
- phiL_NCEN low: all registers hold, including slot_owner. Pulses are cleared the next phiA cycle regardless of CE.
- Reset mid-slot: immediate OWN_IDLE; no ack is issued for any request pending at reset.

Optional Feature:
- Macro: IKA9958_VRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs cpu_grant_cnt[15:0] and cmd_grant_cnt[15:0] plus input stats_clr.
  - The counters count acks and saturate at 16'hFFFF.
  - stats_clr is synchronous, CE-independent, and has priority over increment.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent. Arbitration is identical.

Decomposition:
- Package IKA9958_mnemonics holds:
  - typedef enum logic[2:0] slot_owner_t {OWN_IDLE=0, OWN_DISP=1, OWN_REFRESH=2, OWN_CPU=3, OWN_CMD=4}.
  - Constants SLOT_LEN=4, TXT_TILE_SLOTS=3, GFX_TILE_SLOTS=4.
- One sub-module, ika9958_vram_slot_arb_rr: two-requester round-robin (last_free register plus grant logic), reusable for other shared ports.

Test Plan:
- Graphics mode, disp_active=1, cmd_req held, comcntr 9'h050..9'h05F: owner DISP at 0x50/0x54/0x58 and CMD at 0x5C; one cmd_ack pulse.
- Text mode, disp_active=1, cpu_req held, comcntr 9'h060..9'h06B with tile reload: DISP at 0x60/0x64, CPU at 0x68; no boundary between 0x6B and the reload.
- disp_active=0, cpu_req and cmd_req held continuously (re-raised after ack): grants alternate CPU, CMD, CPU, CMD; CPU wins first after reset.
- comcntr=REFRESH_POS (9'h1F8) with cpu_req=1 and disp_active=1: owner REFRESH, no cpu_ack; CPU granted at the next free slot.
- RST_async asserted mid CPU slot: slot_owner=IDLE same cycle without a clock edge; acks 0; last_free=CMD after release.
- STATS_EN: 70000 CPU grants -> cpu_grant_cnt=16'hFFFF; stats_clr coincident with a grant -> 0.
